// File: rtl/color_unscramble_stream_pkg.sv
// Shared types and constants for the colour-unscramble stream.
package color_unscramble_stream_pkg;

  localparam int unsigned CH_W  = 8;
  localparam int unsigned PIX_W = 3 * CH_W;
  localparam int unsigned CFG_W = 6;

  typedef logic [CFG_W-1:0] cfg_t;

  // Identity code: R from R, G from G, B from B.
  localparam cfg_t ID_CODE = 6'b00_01_10;

  // Source selector held in each 2-bit switch field.
  typedef enum logic [1:0] {
    SRC_R    = 2'b00,
    SRC_G    = 2'b01,
    SRC_B    = 2'b10,
    SRC_ZERO = 2'b11
  } src_e;

  // A code is a permutation when no field selects zero and all three fields differ.
  function automatic logic is_permutation(input cfg_t code);
    logic [1:0] fr;
    logic [1:0] fg;
    logic [1:0] fb;
    fr = code[5:4];
    fg = code[3:2];
    fb = code[1:0];
    return (fr != SRC_ZERO) && (fg != SRC_ZERO) && (fb != SRC_ZERO) &&
           (fr != fg) && (fr != fb) && (fg != fb);
  endfunction

endpackage

// File: rtl/color_unscramble_stream_if.sv
// Valid/ready pixel stream carrying a start-of-frame marker.
interface color_unscramble_stream_if;
  import color_unscramble_stream_pkg::*;

  logic [PIX_W-1:0] pixel;
  logic             valid;
  logic             sof;
  logic             ready;

  modport master (
    output pixel,
    output valid,
    output sof,
    input  ready
  );

  modport slave (
    input  pixel,
    input  valid,
    input  sof,
    output ready
  );

endinterface

// File: rtl/color_unscramble_stream_unscramble_map.sv
// Combinational inverse channel map: given a scrambled pixel and the code that
// scrambled it, rebuild the original R/G/B order and flag non-invertible codes.
module color_unscramble_stream_unscramble_map
  import color_unscramble_stream_pkg::*;
(
  input  logic [PIX_W-1:0] pixel,
  input  cfg_t             cfg,
  output logic [PIX_W-1:0] pixel_out,
  output logic             lossy
);

  logic [CH_W-1:0] sc_r;
  logic [CH_W-1:0] sc_g;
  logic [CH_W-1:0] sc_b;

  assign sc_r = pixel[23:16];
  assign sc_g = pixel[15:8];
  assign sc_b = pixel[7:0];

  // Original channel `want` sits in the first scrambled slot (R, G, B order)
  // whose field names it; with no such slot the channel is lost.
  function automatic logic [CH_W-1:0] recover(input src_e want, input cfg_t code,
                                              input logic [CH_W-1:0] r,
                                              input logic [CH_W-1:0] g,
                                              input logic [CH_W-1:0] b);
    if (code[5:4] == want) begin
      return r;
    end else if (code[3:2] == want) begin
      return g;
    end else if (code[1:0] == want) begin
      return b;
    end
    return '0;
  endfunction

  // Rebuild each original channel and flag codes that cannot be inverted.
  always_comb begin
    pixel_out        = '0;
    pixel_out[23:16] = recover(SRC_R, cfg, sc_r, sc_g, sc_b);
    pixel_out[15:8]  = recover(SRC_G, cfg, sc_r, sc_g, sc_b);
    pixel_out[7:0]   = recover(SRC_B, cfg, sc_r, sc_g, sc_b);
    lossy            = !is_permutation(cfg);
  end

endmodule

// File: rtl/color_unscramble_stream.sv
// Two-stage streaming inverse of the channel-scramble stage.
// The switch code is latched only on an accepted start-of-frame beat, so one
// frame is always decoded with a single code.
// Optional frame statistics: define COLOR_UNSCRAMBLE_STATS_EN.
module color_unscramble_stream
  import color_unscramble_stream_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  cfg_t sw,
  color_unscramble_stream_if.slave  s,
  color_unscramble_stream_if.master m,
  output logic lossy
`ifdef COLOR_UNSCRAMBLE_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] lossy_frame_cnt
`endif
);

  logic adv1;
  logic adv2;
  logic accept;
  logic sof_accept;

  logic             v1_q, v1_d;
  logic             sof1_q, sof1_d;
  logic [PIX_W-1:0] pix1_q, pix1_d;
  cfg_t             cfg_q, cfg_d;

  logic             v2_q, v2_d;
  logic             sof2_q, sof2_d;
  logic [PIX_W-1:0] pix2_q, pix2_d;

  logic [PIX_W-1:0] map_pixel;

  assign adv2       = !v2_q || m.ready;
  assign adv1       = !v1_q || adv2;
  assign accept     = s.valid && adv1;
  assign sof_accept = accept && s.sof;
  assign s.ready    = adv1;

  // Stage 1 next state: capture the beat; an SOF beat loads the new code.
  // cfg_q only changes on an accept, which also moves any older stage-1 pixel
  // on, so cfg_q always is the code of the pixel sitting in stage 1.
  always_comb begin
    v1_d   = v1_q;
    sof1_d = sof1_q;
    pix1_d = pix1_q;
    cfg_d  = cfg_q;
    if (adv1) begin
      v1_d = s.valid;
    end
    if (accept) begin
      pix1_d = s.pixel;
      sof1_d = s.sof;
    end
    if (sof_accept) begin
      cfg_d = sw;
    end
  end

  // Stage 1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      sof1_q <= 1'b0;
      pix1_q <= '0;
      cfg_q  <= ID_CODE;
    end else begin
      v1_q   <= v1_d;
      sof1_q <= sof1_d;
      pix1_q <= pix1_d;
      cfg_q  <= cfg_d;
    end
  end

  color_unscramble_stream_unscramble_map u_unscramble_map (
    .pixel     (pix1_q),
    .cfg       (cfg_q),
    .pixel_out (map_pixel),
    .lossy     (lossy)
  );

  // Stage 2 next state: take the mapped pixel when the output slot frees up.
  always_comb begin
    v2_d   = v2_q;
    sof2_d = sof2_q;
    pix2_d = pix2_q;
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        pix2_d = map_pixel;
        sof2_d = sof1_q;
      end else begin
        sof2_d = 1'b0;
      end
    end
  end

  // Stage 2 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      sof2_q <= 1'b0;
      pix2_q <= '0;
    end else begin
      v2_q   <= v2_d;
      sof2_q <= sof2_d;
      pix2_q <= pix2_d;
    end
  end

  assign m.valid = v2_q;
  assign m.sof   = sof2_q;
  assign m.pixel = pix2_q;

`ifdef COLOR_UNSCRAMBLE_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] lossy_frame_cnt_q, lossy_frame_cnt_d;

  // Saturating frame counters, bumped on each accepted SOF.
  always_comb begin
    frame_cnt_d       = frame_cnt_q;
    lossy_frame_cnt_d = lossy_frame_cnt_q;
    if (sof_accept) begin
      if (frame_cnt_q != 16'hFFFF) begin
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
      if (!is_permutation(sw) && (lossy_frame_cnt_q != 16'hFFFF)) begin
        lossy_frame_cnt_d = lossy_frame_cnt_q + 16'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q       <= '0;
      lossy_frame_cnt_q <= '0;
    end else begin
      frame_cnt_q       <= frame_cnt_d;
      lossy_frame_cnt_q <= lossy_frame_cnt_d;
    end
  end

  assign frame_cnt       = frame_cnt_q;
  assign lossy_frame_cnt = lossy_frame_cnt_q;
`endif

endmodule
